// File: rtl/dispatcher_pulse.sv
// Single-producer to multi-consumer pulse dispatcher with per-channel FIFOs.
// Optional broadcast strobe is enabled by defining DISPATCH_BCAST_EN.
module dispatcher_pulse #(
  parameter int TOTAL = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int SW = (TOTAL > 1) ? $clog2(TOTAL) : 1,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef DISPATCH_BCAST_EN
  input  logic               in_bcast,
`endif
  input  logic               in_stb,
  input  logic [SW-1:0]      in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [TOTAL-1:0]   full,
  output logic               drop,
  output logic [7:0]         drop_cnt,
  output logic [TOTAL*WIDTH-1:0] out_data,
  output logic [TOTAL-1:0]   out_stb,
  input  logic [TOTAL-1:0]   out_rdy,
  output logic [TOTAL-1:0]   pending
);

  localparam logic [SW:0] TOT = TOTAL[SW:0];

  logic             bcast;
  logic             sel_ok;
  logic             drop_d;
  logic [TOTAL-1:0] hit;

`ifdef DISPATCH_BCAST_EN
  assign bcast = in_stb & in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign sel_ok = ({1'b0, in_sel} < TOT);

  // A full target drops the strobe even if it pops this same cycle.
  assign drop_d = in_stb & ((~bcast & ~sel_ok) | (|(hit & full)));

  for (genvar i = 0; i < TOTAL; i++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    assign hit[i] = in_stb & (bcast | (in_sel == SW'(i)));
    assign push   = hit[i] & ~full[i];
    assign pop    = out_stb[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          mem[k] <= '0;
        end
      end else begin
        if (push) begin
          mem[wp] <= in_data;
          wp      <= wp + 1'b1;
        end
        if (pop) begin
          rp <= rp + 1'b1;
        end
        cnt <= cnt + CW'(push) - CW'(pop);
      end
    end

    assign pending[i] = |cnt;
    assign full[i]    = (cnt == CW'(DEPTH));
    assign out_stb[i] = pending[i] & out_rdy[i];
    assign out_data[WIDTH*i +: WIDTH] = mem[rp];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop <= drop_d;
      if (drop_d && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dispatcher_pulse.sv
// Directed bench for dispatcher_pulse (TOTAL=3 so an out-of-range select
// is encodable); table rows plus hand sequences for multi-cycle cases.
module tb_dispatcher_pulse;

  localparam int TOTAL = 3;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        in_stb;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [2:0]  full;
  logic        drop;
  logic [7:0]  drop_cnt;
  logic [23:0] out_data;
  logic [2:0]  out_stb;
  logic [2:0]  out_rdy;
  logic [2:0]  pending;
`ifdef DISPATCH_BCAST_EN
  logic        in_bcast;
`endif

  int checks = 0;
  int errors = 0;

  dispatcher_pulse #(
    .TOTAL(TOTAL),
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef DISPATCH_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .in_stb(in_stb),
    .in_sel(in_sel),
    .in_data(in_data),
    .full(full),
    .drop(drop),
    .drop_cnt(drop_cnt),
    .out_data(out_data),
    .out_stb(out_stb),
    .out_rdy(out_rdy),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stb;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [2:0]  rdy;
    logic [2:0]  pend;
    logic [2:0]  full;
    logic        drop;
    logic [7:0]  dcnt;
    logic [2:0]  ostb;
    logic [23:0] od;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stb, input logic [1:0] sel,
                       input logic [7:0] data, input logic [2:0] rdy);
    @(negedge clk);
    in_stb  = stb;
    in_sel  = sel;
    in_data = data;
    out_rdy = rdy;
    #1;
  endtask

  initial begin
    // Expected outputs reflect state after the previous row's edge.
    tv[0]  = '{0, 0, 8'h00, 3'b000, 3'b000, 3'b000, 0, 8'd0, 3'b000, 24'h000000};
    tv[1]  = '{1, 1, 8'hA5, 3'b000, 3'b000, 3'b000, 0, 8'd0, 3'b000, 24'h000000};
    tv[2]  = '{0, 0, 8'h00, 3'b000, 3'b010, 3'b000, 0, 8'd0, 3'b000, 24'h00A500};
    tv[3]  = '{0, 0, 8'h00, 3'b010, 3'b010, 3'b000, 0, 8'd0, 3'b010, 24'h00A500};
    tv[4]  = '{0, 0, 8'h00, 3'b010, 3'b000, 3'b000, 0, 8'd0, 3'b000, 24'h000000};
    tv[5]  = '{1, 0, 8'h11, 3'b000, 3'b000, 3'b000, 0, 8'd0, 3'b000, 24'h000000};
    tv[6]  = '{1, 0, 8'h22, 3'b000, 3'b001, 3'b000, 0, 8'd0, 3'b000, 24'h000011};
    tv[7]  = '{1, 0, 8'h33, 3'b000, 3'b001, 3'b001, 0, 8'd0, 3'b000, 24'h000011};
    tv[8]  = '{0, 0, 8'h00, 3'b000, 3'b001, 3'b001, 1, 8'd1, 3'b000, 24'h000011};
    tv[9]  = '{0, 0, 8'h00, 3'b001, 3'b001, 3'b001, 0, 8'd1, 3'b001, 24'h000011};
    tv[10] = '{0, 0, 8'h00, 3'b001, 3'b001, 3'b000, 0, 8'd1, 3'b001, 24'h000022};
    tv[11] = '{0, 0, 8'h00, 3'b000, 3'b000, 3'b000, 0, 8'd1, 3'b000, 24'h000011};

    rst_n   = 1'b0;
    in_stb  = 1'b0;
    in_sel  = '0;
    in_data = '0;
    out_rdy = '0;
`ifdef DISPATCH_BCAST_EN
    in_bcast = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].stb, tv[i].sel, tv[i].data, tv[i].rdy);
      chk($sformatf("row%0d pending", i), 32'(pending), 32'(tv[i].pend));
      chk($sformatf("row%0d full", i), 32'(full), 32'(tv[i].full));
      chk($sformatf("row%0d drop", i), 32'(drop), 32'(tv[i].drop));
      chk($sformatf("row%0d drop_cnt", i), 32'(drop_cnt), 32'(tv[i].dcnt));
      chk($sformatf("row%0d out_stb", i), 32'(out_stb), 32'(tv[i].ostb));
      chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tv[i].od));
    end

    // Streaming: one word per cycle with out_rdy[0] held high.
    for (int k = 1; k <= 10; k++) begin
      drive(k <= 8, 2'd0, 8'(k), 3'b001);
      if (k >= 2 && k <= 9) begin
        chk("stream out_stb", 32'(out_stb[0]), 32'd1);
        chk("stream data", 32'(out_data[7:0]), 32'(k - 1));
      end else begin
        chk("stream idle out_stb", 32'(out_stb[0]), 32'd0);
      end
      chk("stream full", 32'(full), 32'd0);
    end

    // Out-of-range select: isolated drop pulse, then saturation.
    drive(1'b1, 2'd3, 8'hEE, 3'b000);
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    chk("badsel drop", 32'(drop), 32'd1);
    chk("badsel pending", 32'(pending), 32'd0);
    chk("badsel drop_cnt", 32'(drop_cnt), 32'd2);
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    chk("badsel drop clear", 32'(drop), 32'd0);
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 2'd3, 8'(k), 3'b000);
    end
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    chk("sat drop", 32'(drop), 32'd1);
    chk("sat drop_cnt", 32'(drop_cnt), 32'd255);
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    chk("sat hold drop_cnt", 32'(drop_cnt), 32'd255);
    chk("sat drop clear", 32'(drop), 32'd0);

    // Asynchronous reset mid-cycle with channel 1 full and channel 0 popping.
    drive(1'b1, 2'd1, 8'h71, 3'b000);
    drive(1'b1, 2'd1, 8'h72, 3'b000);
    drive(1'b1, 2'd0, 8'h73, 3'b000);
    drive(1'b0, 2'd0, 8'h00, 3'b001);
    chk("pre-rst full", 32'(full), 32'b010);
    chk("pre-rst out_stb", 32'(out_stb), 32'b001);
    chk("pre-rst pending", 32'(pending), 32'b011);
    #1 rst_n = 1'b0;
    #1;
    chk("rst pending", 32'(pending), 32'd0);
    chk("rst full", 32'(full), 32'd0);
    chk("rst out_stb", 32'(out_stb), 32'd0);
    chk("rst drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst drop", 32'(drop), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    chk("post-rst pending", 32'(pending), 32'd0);

`ifdef DISPATCH_BCAST_EN
    drive(1'b1, 2'd0, 8'h01, 3'b000);
    drive(1'b1, 2'd0, 8'h02, 3'b000);
    @(negedge clk);
    in_stb   = 1'b1;
    in_bcast = 1'b1;
    in_sel   = 2'd0;
    in_data  = 8'h5A;
    out_rdy  = 3'b000;
    #1;
    chk("bc pre full", 32'(full), 32'b001);
    @(negedge clk);
    in_stb   = 1'b0;
    in_bcast = 1'b0;
    #1;
    chk("bc drop", 32'(drop), 32'd1);
    chk("bc drop_cnt", 32'(drop_cnt), 32'd1);
    chk("bc pending", 32'(pending), 32'b111);
    chk("bc out_data", 32'(out_data), 32'h5A5A01);
    drive(1'b0, 2'd0, 8'h00, 3'b001);
    chk("bc drop clear", 32'(drop), 32'd0);
    drive(1'b0, 2'd0, 8'h00, 3'b000);
    chk("bc ch0 second", 32'(out_data[7:0]), 32'h02);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
